// File: rtl/tytra_stream_pkg.sv
// Shared definitions for TyTra stream leaf nodes: FloPoCo exception codes,
// the single-precision FloPoCo word layout and a constant-foldable clog2.
package tytra_stream_pkg;

   typedef enum logic [1:0] {
      EXN_ZERO   = 2'b00,
      EXN_NORMAL = 2'b01,
      EXN_INF    = 2'b10,
      EXN_NAN    = 2'b11
   } fpc_exn_e;

   localparam logic [1:0] FPC_EF_NORMAL = 2'b01;
   localparam int         FPC_SP_W      = 34;

   typedef struct packed {
      fpc_exn_e    exn;
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fpc_sp_t;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/coriolis_map_fpmul_pipe_if.sv
// Valid/ready stream bundle of the multiply map node: two operand streams in,
// one product stream out, plus the occupancy count.
interface coriolis_map_fpmul_pipe_if
   import tytra_stream_pkg::*;
#(
   parameter int STREAMW = FPC_SP_W,
   parameter int NLANES  = 1,
   parameter int LAT     = 3
) ();

   logic                         ivalid_in1_s0;
   logic [NLANES*STREAMW-1:0]    in1_s0;
   logic                         ivalid_in2_s0;
   logic [NLANES*STREAMW-1:0]    in2_s0;
   logic                         iready;
   logic                         ovalid;
   logic [NLANES*STREAMW-1:0]    out1_s0;
   logic                         oready;
   logic [clog2(LAT+2)-1:0]      inflight;

   modport slave (
      input  ivalid_in1_s0, in1_s0, ivalid_in2_s0, in2_s0, oready,
      output iready, ovalid, out1_s0, inflight
   );

   modport master (
      output ivalid_in1_s0, in1_s0, ivalid_in2_s0, in2_s0, oready,
      input  iready, ovalid, out1_s0, inflight
   );

endinterface

// File: rtl/FPMult_8_23_8_23_8_23_F400_uid2.sv
// FloPoCo-format single-precision multiplier, round-to-nearest-even, no
// subnormals, with a DEPTH-stage stallable result pipeline.
module FPMult_8_23_8_23_8_23_F400_uid2
   import tytra_stream_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic                clk,
   input  logic                stall,
   input  logic [FPC_SP_W-1:0] X,
   input  logic [FPC_SP_W-1:0] Y,
   output logic [FPC_SP_W-1:0] R
);

   fpc_sp_t     x, y, prod;
   fpc_sp_t     stage [DEPTH];
   logic [47:0] mx, my, mant_prod;
   logic [9:0]  exp_sum;
   logic [22:0] frac_trunc;
   logic        guard, sticky, round_bit;
   logic [32:0] exp_frac;

   assign x = X;
   assign y = Y;

   always_comb begin
      mx        = {24'd0, 1'b1, x.frac};
      my        = {24'd0, 1'b1, y.frac};
      mant_prod = mx * my;
      exp_sum   = {2'b00, x.exp} + {2'b00, y.exp} - 10'd127 + {9'd0, mant_prod[47]};
      if (mant_prod[47]) begin
         frac_trunc = mant_prod[46:24];
         guard      = mant_prod[23];
         sticky     = |mant_prod[22:0];
      end else begin
         frac_trunc = mant_prod[45:23];
         guard      = mant_prod[22];
         sticky     = |mant_prod[21:0];
      end
      round_bit = guard & (sticky | frac_trunc[0]);
      // Rounding carry ripples straight into the (signed) exponent field.
      exp_frac  = {exp_sum, frac_trunc} + {32'd0, round_bit};

      prod      = '0;
      prod.sign = x.sign ^ y.sign;
      if (x.exn == EXN_NAN || y.exn == EXN_NAN ||
          (x.exn == EXN_INF && y.exn == EXN_ZERO) ||
          (x.exn == EXN_ZERO && y.exn == EXN_INF)) begin
         prod.exn = EXN_NAN;
      end else if (x.exn == EXN_INF || y.exn == EXN_INF) begin
         prod.exn = EXN_INF;
      end else if (x.exn == EXN_ZERO || y.exn == EXN_ZERO) begin
         prod.exn = EXN_ZERO;
      end else if (exp_frac[32] || exp_frac[32:23] == 10'd0) begin
         prod.exn = EXN_ZERO;
      end else if (exp_frac[32:23] >= 10'd255) begin
         prod.exn = EXN_INF;
      end else begin
         prod.exn  = EXN_NORMAL;
         prod.exp  = exp_frac[30:23];
         prod.frac = exp_frac[22:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         stage[0] <= prod;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign R = stage[DEPTH-1];

endmodule

// File: rtl/tytra_valid_pipe.sv
// Valid-bit shift register that tracks items through a stallable core;
// bubbles shift like real items so the valid stays aligned with the data.
module tytra_valid_pipe #(
   parameter int LAT = 3
) (
   input  logic clk,
   input  logic clear,
   input  logic enable,
   input  logic din,
   output logic dout
);

   logic [LAT-1:0] v_reg;

   generate
      if (LAT == 1) begin : g_one
         always_ff @(posedge clk) begin
            if (clear)       v_reg <= '0;
            else if (enable) v_reg <= din;
         end
      end else begin : g_shift
         always_ff @(posedge clk) begin
            if (clear)       v_reg <= '0;
            else if (enable) v_reg <= {v_reg[LAT-2:0], din};
         end
      end
   endgenerate

   assign dout = v_reg[LAT-1];

endmodule

// File: rtl/coriolis_map_fpmul_pipe.sv
// Elastic N-lane floating-point multiply map node: joins the operand streams,
// runs the stallable multiplier cores and holds results in an output register.
module coriolis_map_fpmul_pipe
   import tytra_stream_pkg::*;
#(
   parameter int                 STREAMW = FPC_SP_W,
   parameter int                 NLANES  = 1,
   parameter int                 LAT     = 3,
   parameter int                 MODE    = 0,
   parameter logic [STREAMW-1:0] CONST_Y = {FPC_EF_NORMAL, 32'h43d8_0000}
) (
   input logic                      clk,
   input logic                      rst,
   coriolis_map_fpmul_pipe_if.slave bus
);

   localparam int             IFW = clog2(LAT + 2);
   localparam logic [IFW-1:0] ONE = 1;

   logic                      ivalid, adv, accept, deliver, v_last;
   logic                      ovalid_reg;
   logic [NLANES*STREAMW-1:0] prod, out_reg;
   logic [IFW-1:0]            inflight_reg;

   assign ivalid  = (MODE == 0) ? bus.ivalid_in1_s0 : (bus.ivalid_in1_s0 & bus.ivalid_in2_s0);
   // An empty output slot never blocks, so only a held, unconsumed result stalls.
   assign adv     = ~ovalid_reg | bus.oready;
   assign accept  = ivalid & adv;
   assign deliver = ovalid_reg & bus.oready;

   tytra_valid_pipe #(.LAT(LAT)) u_vpipe (
      .clk    (clk),
      .clear  (rst),
      .enable (adv),
      .din    (ivalid),
      .dout   (v_last)
   );

   generate
      for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
         logic [STREAMW-1:0] op2;
         assign op2 = (MODE == 0) ? CONST_Y : bus.in2_s0[gi*STREAMW +: STREAMW];
         FPMult_8_23_8_23_8_23_F400_uid2 #(.DEPTH(LAT)) u_mul (
            .clk   (clk),
            .stall (~adv),
            .X     (bus.in1_s0[gi*STREAMW +: STREAMW]),
            .Y     (op2),
            .R     (prod[gi*STREAMW +: STREAMW])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         ovalid_reg   <= 1'b0;
         out_reg      <= '0;
         inflight_reg <= '0;
      end else begin
         if (adv) begin
            out_reg    <= prod;
            ovalid_reg <= v_last;
         end
         if (accept && !deliver)      inflight_reg <= inflight_reg + ONE;
         else if (!accept && deliver) inflight_reg <= inflight_reg - ONE;
      end
   end

   assign bus.iready   = adv;
   assign bus.ovalid   = ovalid_reg;
   assign bus.out1_s0  = out_reg;
   assign bus.inflight = inflight_reg;

endmodule

// File: tb/tb_coriolis_map_fpmul_pipe.sv
// Scoreboard bench for the multiply map node: a constant-operand single-lane
// instance and a two-stream dual-lane instance against a real-arithmetic model.
module tb_coriolis_map_fpmul_pipe;

   localparam logic [33:0] CY = 34'h1_43d8_0000;

   typedef struct {
      logic [67:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   ca = 0, cb = 0;
   int   outs_a = 0, outs_b = 0;
   bit   lat_chk = 1'b1;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   coriolis_map_fpmul_pipe_if #(.STREAMW(34), .NLANES(1), .LAT(3)) a_if ();
   coriolis_map_fpmul_pipe_if #(.STREAMW(34), .NLANES(2), .LAT(3)) b_if ();

   coriolis_map_fpmul_pipe #(.STREAMW(34), .NLANES(1), .LAT(3), .MODE(0)) dut_a (
      .clk (clk), .rst (rst), .bus (a_if)
   );
   coriolis_map_fpmul_pipe #(.STREAMW(34), .NLANES(2), .LAT(3), .MODE(1)) dut_b (
      .clk (clk), .rst (rst), .bus (b_if)
   );

   task automatic check(input string name, input logic [67:0] act, input logic [67:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic real to_real(input logic [30:0] ef);
      return $bitstoreal({1'b0, 11'(int'(ef[30:23]) - 127 + 1023), ef[22:0], 29'd0});
   endfunction

   function automatic logic [33:0] sp(input real r);
      logic [63:0] b;
      b = $realtobits(r);
      return {2'b01, b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
   endfunction

   // Exact product in double, then round-to-nearest-even down to single.
   function automatic logic [33:0] ref_mul(input logic [33:0] x, input logic [33:0] y);
      logic        s, rnd;
      logic [63:0] b;
      logic [22:0] keep, frac;
      logic [28:0] rem;
      logic [24:0] m;
      int          de, be;
      s = x[31] ^ y[31];
      if (x[33:32] == 2'b11 || y[33:32] == 2'b11 ||
          (x[33:32] == 2'b10 && y[33:32] == 2'b00) ||
          (x[33:32] == 2'b00 && y[33:32] == 2'b10)) return {2'b11, s, 31'd0};
      if (x[33:32] == 2'b10 || y[33:32] == 2'b10) return {2'b10, s, 31'd0};
      if (x[33:32] == 2'b00 || y[33:32] == 2'b00) return {2'b00, s, 31'd0};
      b    = $realtobits(to_real(x[30:0]) * to_real(y[30:0]));
      de   = int'(b[62:52]) - 1023;
      keep = b[51:29];
      rem  = b[28:0];
      rnd  = (rem > 29'h1000_0000) || (rem == 29'h1000_0000 && keep[0]);
      m    = {2'b01, keep} + {24'd0, rnd};
      if (m[24]) begin
         de   = de + 1;
         frac = m[23:1];
      end else begin
         frac = m[22:0];
      end
      be = de + 127;
      if (be >= 255) return {2'b10, s, 31'd0};
      if (be <= 0)   return {2'b00, s, 31'd0};
      return {2'b01, s, 8'(be), frac};
   endfunction

   function automatic logic [33:0] rand_op();
      int sel;
      sel = int'($urandom_range(0, 15));
      case (sel)
         0:       return {2'b00, 1'($urandom), 31'd0};
         1:       return {2'b10, 1'($urandom), 31'd0};
         2:       return {2'b11, 1'($urandom), 31'd0};
         3:       return {2'b01, 1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
         default: return {2'b01, 1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      endcase
   endfunction

   // Input side: every accepted beat pushes its expected product.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (a_if.ivalid_in1_s0 && a_if.iready) begin
            e.data = {34'd0, ref_mul(a_if.in1_s0, CY)};
            e.cyc  = cyc;
            qa.push_back(e);
         end
         if (b_if.ivalid_in1_s0 && b_if.ivalid_in2_s0 && b_if.iready) begin
            e.data = {ref_mul(b_if.in1_s0[67:34], b_if.in2_s0[67:34]),
                      ref_mul(b_if.in1_s0[33:0],  b_if.in2_s0[33:0])};
            e.cyc  = cyc;
            qb.push_back(e);
         end
      end
   end

   // Output side for the constant-operand instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         qa.delete();
         ca = 0;
      end else begin
         check("a_inflight", a_if.inflight, ca);
         check("a_iready", a_if.iready, !(a_if.ovalid && !a_if.oready));
         if (a_if.ovalid && a_if.oready) begin
            outs_a++;
            if (qa.size() == 0) begin
               total++; bad++;
               $display("FAIL a_spurious: got ovalid with %h expected no output (cycle %0d)", a_if.out1_s0, cyc);
            end else begin
               e = qa.pop_front();
               check("a_data", a_if.out1_s0, e.data);
               if (lat_chk) check("a_latency", cyc - e.cyc, 4);
            end
         end
         ca = ca + int'(a_if.ivalid_in1_s0 && a_if.iready) - int'(a_if.ovalid && a_if.oready);
      end
   end

   // Output side for the two-stream instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         qb.delete();
         cb = 0;
      end else begin
         check("b_inflight", b_if.inflight, cb);
         check("b_iready", b_if.iready, !(b_if.ovalid && !b_if.oready));
         if (b_if.ovalid && b_if.oready) begin
            outs_b++;
            if (qb.size() == 0) begin
               total++; bad++;
               $display("FAIL b_spurious: got ovalid with %h expected no output (cycle %0d)", b_if.out1_s0, cyc);
            end else begin
               e = qb.pop_front();
               check("b_data", b_if.out1_s0, e.data);
               if (lat_chk) check("b_latency", cyc - e.cyc, 4);
            end
         end
         cb = cb + int'(b_if.ivalid_in1_s0 && b_if.ivalid_in2_s0 && b_if.iready)
                 - int'(b_if.ovalid && b_if.oready);
      end
   end

   task automatic drive(input bit va, input logic [33:0] da, input bit v1, input bit v2,
                        input logic [67:0] d1, input logic [67:0] d2, input bit ra, input bit rb);
      @(posedge clk);
      #1;
      a_if.ivalid_in1_s0 = va;  a_if.in1_s0 = da;  a_if.oready = ra;
      b_if.ivalid_in1_s0 = v1;  b_if.in1_s0 = d1;
      b_if.ivalid_in2_s0 = v2;  b_if.in2_s0 = d2;  b_if.oready = rb;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, '0, 0, 0, '0, '0, 1, 1);
   endtask

   initial begin
      int          k, peak, base_a, base_b;
      bit          seen, stalled;
      logic [33:0] held;
      a_if.ivalid_in1_s0 = 0; a_if.in1_s0 = '0; a_if.ivalid_in2_s0 = 0; a_if.in2_s0 = '0; a_if.oready = 1;
      b_if.ivalid_in1_s0 = 0; b_if.in1_s0 = '0; b_if.ivalid_in2_s0 = 0; b_if.in2_s0 = '0; b_if.oready = 1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_a_ovalid", a_if.ovalid, 0);
      check("rst_a_out", a_if.out1_s0, 0);
      check("rst_a_inflight", a_if.inflight, 0);
      check("rst_a_iready", a_if.iready, 1);
      check("rst_b_ovalid", b_if.ovalid, 0);
      check("rst_b_out", b_if.out1_s0, 0);

      // Single beat: 2.0 * 432.0 appears exactly 4 cycles after acceptance, for one cycle.
      drive(1, 34'h1_4000_0000, 0, 0, '0, '0, 1, 1);
      for (int i = 1; i <= 6; i++) begin
         drive(0, '0, 0, 0, '0, '0, 1, 1);
         @(negedge clk);
         check("single_ovalid", a_if.ovalid, (i == 4));
         if (i == 4) check("single_data", a_if.out1_s0, 34'h1_4458_0000);
      end

      // Back-to-back stream of 1.0 .. 16.0.
      base_a = outs_a;
      peak = 0;
      for (int i = 1; i <= 16; i++) begin
         drive(1, sp(real'(i)), 0, 0, '0, '0, 1, 1);
         @(negedge clk);
         if (int'(a_if.inflight) > peak) peak = int'(a_if.inflight);
      end
      idle(8);
      check("stream_peak_inflight", peak, 4);
      check("stream_count", outs_a - base_a, 16);

      // Backpressure: oready low for 5 cycles in the middle of a stream.
      lat_chk = 0;
      base_a = outs_a;
      k = 1;
      stalled = 0;
      held = '0;
      for (int i = 0; i < 30; i++) begin
         drive(k <= 12, sp(real'(k) + 0.5), 0, 0, '0, '0, !(i >= 6 && i < 11), 1);
         @(negedge clk);
         if (stalled) begin
            check("bp_hold_data", a_if.out1_s0, held);
            check("bp_hold_valid", a_if.ovalid, 1);
         end
         held    = a_if.out1_s0;
         stalled = a_if.ovalid && !a_if.oready;
         if (k <= 12 && a_if.iready) k++;
      end
      check("bp_count", outs_a - base_a, 12);

      // Bubbles: alternating valid must come out with the same spacing.
      lat_chk = 1;
      base_a = outs_a;
      for (int i = 0; i < 12; i++) drive(i % 2 == 0, sp(real'(i + 3)), 0, 0, '0, '0, 1, 1);
      idle(8);
      check("bubble_count", outs_a - base_a, 6);

      // Two-stream join: operand 2 turns valid two cycles after operand 1.
      base_b = outs_b;
      for (int i = 0; i < 3; i++)
         drive(0, '0, 1, i == 2, {sp(-1.5), sp(3.0)}, {sp(2.0), sp(4.0)}, 1, 1);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         drive(0, '0, 0, 0, '0, '0, 1, 1);
         @(negedge clk);
         if (b_if.ovalid) begin
            seen = 1;
            check("join_data", b_if.out1_s0, {34'h1_C040_0000, 34'h1_4140_0000});
         end
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL join_timeout: got no ovalid expected one output within 10 cycles");
      end
      idle(6);
      check("join_count", outs_b - base_b, 1);

      // Randomized operands, valids and backpressure on both instances.
      lat_chk = 0;
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 9) < 7, rand_op(),
               $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
               {rand_op(), rand_op()}, {rand_op(), rand_op()},
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      idle(10);
      check("rand_a_drained", qa.size(), 0);
      check("rand_b_drained", qb.size(), 0);

      // Reset with three items in flight discards them.
      lat_chk = 1;
      for (int i = 0; i < 3; i++)
         drive(1, sp(real'(i + 7)), 1, 1, {sp(1.0), sp(2.0)}, {sp(3.0), sp(5.0)}, 1, 1);
      drive(0, '0, 0, 0, '0, '0, 1, 1);
      rst = 1'b1;
      base_a = outs_a;
      base_b = outs_b;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_a_ovalid", a_if.ovalid, 0);
      check("mid_rst_a_inflight", a_if.inflight, 0);
      check("mid_rst_a_iready", a_if.iready, 1);
      check("mid_rst_b_ovalid", b_if.ovalid, 0);
      check("mid_rst_b_inflight", b_if.inflight, 0);
      idle(10);
      check("mid_rst_a_stale", outs_a - base_a, 0);
      check("mid_rst_b_stale", outs_b - base_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/coriolis_map_fpmul_pipe.md
# coriolis_map_fpmul_pipe

Parametrised leaf map node for the TyTra back-end: an elastic, N-lane FloPoCo floating-point multiply stage with a stall-aware valid pipeline and a registered output. It generalises the fixed-constant multiply node. The second operand is either a compile-time constant or a second input stream, and the datapath width, core latency and lane count are parameters. It sits between upstream and downstream map nodes in a kernel pipeline, using the valid/ready stream handshake.

## Interface
- `STREAMW`, 34: per-lane operand width, FloPoCo format (2 exception bits + IEEE single).
- `NLANES`, 1: parallel lanes sharing one handshake.
- `LAT`, 3: pipeline latency of the multiplier core, in cycles (≥1).
- `MODE`, 0: 0 = operand 2 is a constant; 1 = operand 2 is a stream.
- `CONST_Y`, {2'b01, 32'h43d80000}: operand 2 when MODE=0 (432.0), same value in every lane.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ivalid_in1_s0`  in  1  operand-1 valid.
- `in1_s0`  in  NLANES*STREAMW  operand 1; lane k is bits [k*STREAMW +: STREAMW].
- `ivalid_in2_s0`  in  1  operand-2 valid; ignored when MODE=0.
- `in2_s0`  in  NLANES*STREAMW  operand 2; ignored when MODE=0.
- `iready`  out  1  node accepts input this cycle.
- `ovalid`  out  1  `out1_s0` holds a valid result.
- `out1_s0`  out  NLANES*STREAMW  registered products.
- `oready`  in  1  downstream accepts output.
- `inflight`  out  clog2(LAT+2)  number of valid items in the core plus the output register.

## Operation
- Join:
  - MODE=0: `ivalid = ivalid_in1_s0`.
  - MODE=1: `ivalid = ivalid_in1_s0 & ivalid_in2_s0`. Both streams are consumed together.
- `adv = ~ovalid | oready`.
  - The core `stall` input is `~adv`.
  - `iready = adv`.
  - An input is accepted when `ivalid & adv`.
- Valid shift register `v[0..LAT-1]`:
  - Shifts only when `adv`.
  - `v[0] <= ivalid` on each shift.
  - Bubbles therefore propagate.
  - This fixes the earlier behaviour, where the valid pipe froze whenever ivalid was low while data kept moving.
- Output register:
  - When `adv`: `out1_s0 <= core R`, `ovalid <= v[LAT-1]`.
  - Otherwise `out1_s0` and `ovalid` hold.
- `ovalid` has no combinational dependence on `oready`. It is held high with stable data until `oready` is asserted.
- `inflight`:
  - +1 on accept, −1 when `ovalid & oready`.
  - Both in the same cycle: unchanged.
  - Never exceeds LAT+1.
- Lanes are independent multiplier instances. No cross-lane arithmetic.
- Exception bits pass through the core untouched. NaN, Inf and zero handling is the core's.

## Timing
- Reset: `ovalid=0`, `out1_s0=0`, `v=0`, `inflight=0`. `iready=1` from the first cycle after reset.
- Reset mid-operation: all in-flight items are discarded with no partial output. Core internal state is don't-care because `v` is cleared.
- Latency: an input accepted in cycle t gives `ovalid=1` in cycle t+LAT+1 if `oready` stays high.
- Throughput: one item per cycle per lane with `oready` held high.
- Backpressure:
  - `oready` low while `ovalid=1` freezes the core, `v`, and the output in the same cycle.
  - `iready` drops combinationally with it.
  - No item is lost or duplicated.
- `oready` low while `ovalid=0`: the pipeline still advances. Empty output slots never block.
- MODE=1 with only one operand valid: nothing is consumed and the pipeline advances with a bubble.

## Structure
- Shared package `tytra_stream_pkg`:
  - `FPC_EF_NORMAL = 2'b01`.
  - The FloPoCo single-precision width constant (34).
  - The `clog2` function.
- The natural sub-module is `tytra_valid_pipe` (parameter LAT; enable, din, dout, clear). It is reusable by other leaf map nodes.
- The multiplier is `FPMult_8_23_8_23_8_23_F400_uid2`, instantiated NLANES times inside a generate loop. LAT must match that core's latency.

## Test plan
- MODE=0, NLANES=1, LAT=3:
  - Stimulus: in1 = 34'h1_4000_0000 (2.0), single beat, `oready=1`.
  - Expected: `out1_s0` = 34'h1_4458_0000 (864.0) and `ovalid` high for exactly one cycle, 4 cycles after accept.
- Streaming:
  - Stimulus: 16 back-to-back beats of 1.0, 2.0, …, 16.0, `oready=1`.
  - Expected: 16 consecutive ovalid cycles, products 432·k in order, `inflight` peaks at 4.
- Backpressure:
  - Stimulus: hold `oready=0` for 5 cycles while streaming.
  - Expected: `iready=0` during the stall, `out1_s0` stable, no loss or duplication, order preserved.
- Bubbles:
  - Stimulus: alternate `ivalid` 1/0.
  - Expected: outputs alternate with the same gaps; no spurious ovalid (regression for the frozen-valid bug).
- MODE=1, NLANES=2:
  - Stimulus: lanes {3.0×4.0, −1.5×2.0}; `ivalid_in2_s0` arrives 2 cycles after `ivalid_in1_s0`.
  - Expected: a single output {12.0 = 34'h1_4140_0000, −3.0 = 34'h1_C040_0000}.
- Reset:
  - Stimulus: assert `rst` with 3 items in flight.
  - Expected: next cycle `ovalid=0`, `inflight=0`, `iready=1`; no stale output emerges afterwards.
